// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller.
// Holds the default parameters and the active-low hex glyph table.
package seg_pkg;

   localparam int DEF_N_DIG    = 8;
   localparam int DEF_CLK_HZ   = 100_000_000;
   localparam int DEF_SLOT_CYC = 6250;
   localparam int DEF_TICK_HZ  = 1;

   // Glyphs as {G,F,E,D,C,B,A}; a 0 bit lights that segment.
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg_hex7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg_hex7
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-frame input snapshots,
// PWM brightness in sixteenths of a slot and an independent tick divider.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int N_DIG    = DEF_N_DIG,
   parameter int CLK_HZ   = DEF_CLK_HZ,
   parameter int SLOT_CYC = DEF_SLOT_CYC,
   parameter int TICK_HZ  = DEF_TICK_HZ
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4*N_DIG-1:0] digits,
   input  logic [N_DIG-1:0]   dp_mask,
   input  logic [N_DIG-1:0]   blank_mask,
   input  logic [3:0]         bright,
   output logic [6:0]         seg,
   output logic               dp,
   output logic [N_DIG-1:0]   an,
   output logic               tick,
   output logic               frame
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int PH_DIV   = SLOT_CYC / 16;
   localparam int SLOT_W   = $clog2(SLOT_CYC);
   localparam int IDX_W    = $clog2(N_DIG);
   localparam int TICK_W   = $clog2(TICK_DIV);

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYC - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIG - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   logic [SLOT_W-1:0]  slot_cnt;
   logic [IDX_W-1:0]   idx;
   logic [TICK_W-1:0]  tick_cnt;
   logic [4*N_DIG-1:0] digits_s;
   logic [N_DIG-1:0]   dp_mask_s;
   logic [N_DIG-1:0]   blank_mask_s;
   logic [3:0]         bright_r;
   logic               snap_valid;

   logic               slot_end;
   logic               frame_end;
   logic [SLOT_W-1:0]  phase_full;
   logic [3:0]         phase;
   logic               an_on;
   logic [3:0]         cur_nib;
   logic [6:0]         seg_dec;
   logic [N_DIG-1:0]   an_next;
   logic [6:0]         seg_next;
   logic               dp_next;

   assign slot_end  = (slot_cnt == SLOT_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);
   assign tick      = (tick_cnt == TICK_LAST);
   assign frame     = frame_end;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_cnt <= '0;
         idx      <= '0;
      end else begin
         slot_cnt <= slot_end ? '0 : slot_cnt + SLOT_W'(1);
         if (slot_end) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
      end
   end

   // The display stays dark until the first full frame has been captured.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digits_s     <= '0;
         dp_mask_s    <= '0;
         blank_mask_s <= '0;
         snap_valid   <= 1'b0;
         bright_r     <= '0;
      end else begin
         if (frame_end) begin
            digits_s     <= digits;
            dp_mask_s    <= dp_mask;
            blank_mask_s <= blank_mask;
            snap_valid   <= 1'b1;
         end
         if (slot_cnt == '0) begin
            bright_r <= bright;
         end
      end
   end

   // Saturate so a slot length that is not a multiple of 16 never wraps to phase 0.
   assign phase_full = slot_cnt / SLOT_W'(PH_DIV);
   assign phase      = (phase_full > SLOT_W'(15)) ? 4'd15 : phase_full[3:0];
   assign cur_nib    = digits_s[4*idx +: 4];

   seg_hex7 u_hex7 (
      .nibble (cur_nib),
      .seg    (seg_dec)
   );

   always_comb begin
      an_on    = snap_valid && (slot_cnt != '0) && (phase < bright_r) && !blank_mask_s[idx];
      an_next  = '1;
      seg_next = 7'h7F;
      dp_next  = 1'b1;
      if (an_on) begin
         an_next[idx] = 1'b0;
         seg_next     = seg_dec;
         dp_next      = ~dp_mask_s[idx];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an  <= '1;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= an_next;
         seg <= seg_next;
         dp  <= dp_next;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a cycle-level expectation of every output.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] digits;
   logic [3:0]  dp_mask;
   logic [3:0]  blank_mask;
   logic [3:0]  bright;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        tick;
   logic        frame;

   int testsRun;
   int testsFailed;
   int k;
   logic [15:0] mDigits;
   logic [3:0]  mDp;
   logic [3:0]  mBlank;
   logic [3:0]  mBright;
   bit          mValid;
   int          lowCnt [4];
   logic [6:0]  segSeen [4];
   int          dpLowCnt;
   int          frameCnt;
   int          tickCnt;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .N_DIG    (4),
      .CLK_HZ   (1600),
      .SLOT_CYC (16),
      .TICK_HZ  (100)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .digits     (digits),
      .dp_mask    (dp_mask),
      .blank_mask (blank_mask),
      .bright     (bright),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .tick       (tick),
      .frame      (frame)
   );

   function automatic logic [6:0] hexSeg(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", tag, k, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpm, input logic [3:0] bm,
                                input logic [3:0] br);
      digits     = d;
      dp_mask    = dpm;
      blank_mask = bm;
      bright     = br;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_an"},    an,    4'hF);
      checkOutput({tag, "_seg"},   seg,   7'h7F);
      checkOutput({tag, "_dp"},    dp,    1'b1);
      checkOutput({tag, "_tick"},  tick,  1'b0);
      checkOutput({tag, "_frame"}, frame, 1'b0);
   endtask

   task automatic resetModel();
      k       = 0;
      mDigits = '0;
      mDp     = '0;
      mBlank  = '0;
      mBright = '0;
      mValid  = 1'b0;
   endtask

   task automatic clearTally();
      for (int i = 0; i < 4; i++) begin
         lowCnt[i]  = 0;
         segSeen[i] = 7'h7F;
      end
      dpLowCnt = 0;
      frameCnt = 0;
      tickCnt  = 0;
   endtask

   // Outputs after edge k+1 show scan position k; snapshots update at the edge leaving the last slot.
   task automatic stepCycle();
      int         slot;
      int         idx;
      bit         lit;
      logic [3:0] expAn;
      logic [6:0] expSeg;
      logic       expDp;
      @(posedge clk);
      slot   = k % 16;
      idx    = (k / 16) % 4;
      lit    = mValid && (slot != 0) && (slot < int'(mBright)) && !mBlank[idx];
      expAn  = 4'hF;
      expSeg = 7'h7F;
      expDp  = 1'b1;
      if (lit) begin
         expAn[idx] = 1'b0;
         expSeg     = hexSeg(mDigits[idx*4 +: 4]);
         expDp      = ~mDp[idx];
      end
      if (slot == 15 && idx == 3) begin
         mDigits = digits;
         mDp     = dp_mask;
         mBlank  = blank_mask;
         mValid  = 1'b1;
      end
      if (slot == 0) mBright = bright;
      k = k + 1;
      @(negedge clk);
      checkOutput("an", an, expAn);
      checkOutput("seg", seg, expSeg);
      checkOutput("dp", dp, expDp);
      checkOutput("tick", tick, (k % 16) == 15);
      checkOutput("frame", frame, (k % 64) == 63);
      checkOutput("an_onehot", $countones(~an) <= 1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (!an[i]) lowCnt[i]++;
         if (an == ~(4'b0001 << i)) segSeen[i] = seg;
      end
      if (!dp) dpLowCnt++;
      if (frame) frameCnt++;
      if (tick) tickCnt++;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      resetModel();
      clearTally();
      rst = 1'b0;
      applyStimulus(16'h1234, 4'b0000, 4'b0000, 4'd15);
      repeat (3) @(negedge clk);
      checkIdle("reset");
      rst = 1'b1;

      // First frame after reset stays dark.
      clearTally();
      runCycles(64);
      checkOutput("dark_low", lowCnt[0] + lowCnt[1] + lowCnt[2] + lowCnt[3], 0);
      checkOutput("dark_frames", frameCnt, 1);

      // Test A: two frames of 1234 at full brightness.
      clearTally();
      runCycles(128);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("A_low_d%0d", i), lowCnt[i], 28);
      checkOutput("A_seg_d0", segSeen[0], 7'h19);
      checkOutput("A_seg_d1", segSeen[1], 7'h30);
      checkOutput("A_seg_d2", segSeen[2], 7'h24);
      checkOutput("A_seg_d3", segSeen[3], 7'h79);
      checkOutput("A_frames", frameCnt, 2);

      // Test B: brightness 4, then 0 applied mid-slot.
      applyStimulus(16'h1234, 4'b0000, 4'b0000, 4'd4);
      clearTally();
      runCycles(64);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("B4_low_d%0d", i), lowCnt[i], 3);
      clearTally();
      runCycles(5);
      applyStimulus(16'h1234, 4'b0000, 4'b0000, 4'd0);
      runCycles(59);
      checkOutput("Bmid_low_d0", lowCnt[0], 3);
      checkOutput("Bmid_low_rest", lowCnt[1] + lowCnt[2] + lowCnt[3], 0);
      clearTally();
      runCycles(64);
      checkOutput("B0_low", lowCnt[0] + lowCnt[1] + lowCnt[2] + lowCnt[3], 0);

      // Test C: masks wait for the frame boundary, brightness does not.
      applyStimulus(16'h1234, 4'b0100, 4'b0010, 4'd15);
      clearTally();
      runCycles(64);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("Cpre_low_d%0d", i), lowCnt[i], 14);
      checkOutput("Cpre_dp", dpLowCnt, 0);
      clearTally();
      runCycles(64);
      checkOutput("C_low_d0", lowCnt[0], 14);
      checkOutput("C_low_d1", lowCnt[1], 0);
      checkOutput("C_low_d2", lowCnt[2], 14);
      checkOutput("C_low_d3", lowCnt[3], 14);
      checkOutput("C_dp", dpLowCnt, 14);

      // Test D: digits change during slot 1, visible only in the next frame.
      applyStimulus(16'h1234, 4'b0000, 4'b0000, 4'd15);
      clearTally();
      runCycles(21);
      applyStimulus(16'hABCD, 4'b0000, 4'b0000, 4'd15);
      runCycles(43);
      checkOutput("Dcur_seg_d0", segSeen[0], 7'h19);
      checkOutput("Dcur_seg_d3", segSeen[3], 7'h79);
      checkOutput("Dcur_frames", frameCnt, 1);
      clearTally();
      runCycles(64);
      checkOutput("Dnext_seg_d0", segSeen[0], 7'h21);
      checkOutput("Dnext_seg_d1", segSeen[1], 7'h46);
      checkOutput("Dnext_seg_d2", segSeen[2], 7'h03);
      checkOutput("Dnext_seg_d3", segSeen[3], 7'h08);
      checkOutput("Dnext_low_d1", lowCnt[1], 14);
      checkOutput("Dnext_frames", frameCnt, 1);

      // Asynchronous reset while a digit is lit.
      runCycles(21);
      checkOutput("pre_rst_an", an, 4'b1101);
      #2;
      rst = 1'b0;
      #1;
      checkIdle("async_rst");
      repeat (3) begin
         @(negedge clk);
         checkIdle("rst_hold");
      end

      // Test E: tick cadence from release, then reset at cycle 40.
      resetModel();
      rst = 1'b1;
      clearTally();
      runCycles(40);
      checkOutput("E_ticks", tickCnt, 2);
      #2;
      rst = 1'b0;
      #1;
      checkIdle("E_rst");
      repeat (2) begin
         @(negedge clk);
         checkIdle("E_rst_hold");
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
